// File: rtl/mux_rr_arbiter.sv
// Round-robin arbitrated N-to-1 mux with a one-deep registered output stage.
// Each requester lane gates its own data onto an AND-OR select bus.

module mux_rr_lane #(
  parameter int WIDTH = 8
) (
  input  logic             i_gnt,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data
);
  assign o_ready = i_gnt & i_load;
  assign o_data  = i_gnt ? i_data : '0;
endmodule

module mux_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int SRC_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       in_valid,
  input  logic [N_REQ*WIDTH-1:0] in_data,
  output logic [N_REQ-1:0]       in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_ready
);

  logic [SRC_W-1:0]            r_ptr;
  logic                        r_out_valid;
  logic [WIDTH-1:0]            r_out_data;
  logic [SRC_W-1:0]            r_out_src;

  logic                        w_load;
  logic                        w_found;
  logic [SRC_W-1:0]            w_win;
  logic [SRC_W-1:0]            w_ptr_nxt;
  logic [N_REQ-1:0]            w_gnt;
  logic [N_REQ-1:0][WIDTH-1:0] w_lane_data;
  logic [WIDTH-1:0]            w_mux;

  assign w_load = ~r_out_valid | out_ready;

  // Scan from r_ptr upward with wrap; first valid requester wins.
  always_comb begin : arb
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, r_ptr} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(N_REQ)) sum = sum - (SRC_W+1)'(N_REQ);
      idx = sum[SRC_W-1:0];
      if (!w_found && in_valid[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  assign w_ptr_nxt = (w_win == SRC_W'(N_REQ-1)) ? '0 : w_win + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign w_gnt[gi] = w_found & (w_win == SRC_W'(gi));
      mux_rr_lane #(.WIDTH(WIDTH)) u_lane (
        .i_gnt   (w_gnt[gi]),
        .i_load  (w_load),
        .i_data  (in_data[gi*WIDTH +: WIDTH]),
        .o_ready (in_ready[gi]),
        .o_data  (w_lane_data[gi])
      );
    end
  endgenerate

  // Grant is one-hot, so OR-reducing the gated lanes selects the winner.
  always_comb begin
    w_mux = '0;
    for (int i = 0; i < N_REQ; i++) w_mux = w_mux | w_lane_data[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_load & w_found) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux;
      r_out_src   <= w_win;
      r_ptr       <= w_ptr_nxt;
    end else if (w_load) begin
      // Drained (or already empty) with nothing to take; data/src keep last word.
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (N_REQ=4, WIDTH=8).
module tb_mux_rr_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int SRC_W = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       in_valid;
  logic [N_REQ*WIDTH-1:0] in_data;
  logic [N_REQ-1:0]       in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [SRC_W-1:0]       out_src;
  logic                   out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  mux_rr_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .SRC_W(SRC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_data_inc();
    for (int i = 0; i < N_REQ; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_chk++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", out_src); end
    for (int c = 0; c < 10; c++) begin
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid c%0d: got %b want 0", c, out_valid); end
      n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready c%0d: got %b want 0000", c, in_ready); end
      n_chk++; if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL idle_ptr c%0d: got %0d want 0", c, dut.r_ptr); end
      tick();
    end
  endtask

  task automatic test_single();
    in_valid  = 4'b0100;
    in_data   = '0;
    in_data[2*WIDTH +: WIDTH] = 8'hA5;
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", in_ready); end
    tick();
    in_valid = 4'b0000;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_chk++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", out_data); end
    n_chk++; if (out_src !== 2'd2) begin n_fail++; $display("FAIL single_src: got %0d want 2", out_src); end
    n_chk++; if (dut.r_ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d want 3", dut.r_ptr); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL drain_data_kept: got %h want a5", out_data); end
    n_chk++; if (dut.r_ptr !== 2'd3) begin n_fail++; $display("FAIL idle_ptr_kept: got %0d want 3", dut.r_ptr); end
  endtask

  task automatic test_contention();
    logic [SRC_W-1:0] exp_src [6];
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    set_data_inc();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cont_valid k%0d: got %b want 1", k, out_valid); end
      n_chk++; if (out_src !== exp_src[k]) begin n_fail++; $display("FAIL cont_src k%0d: got %0d want %0d", k, out_src, exp_src[k]); end
      n_chk++; if (out_data !== 8'h10 + 8'(exp_src[k])) begin n_fail++; $display("FAIL cont_data k%0d: got %h want %h", k, out_data, 8'h10 + 8'(exp_src[k])); end
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data_inc();
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want 0000", c, in_ready); end
      tick();
      n_chk++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL bp_data c%0d: got %h want 11", c, out_data); end
      n_chk++; if (out_src !== 2'd1) begin n_fail++; $display("FAIL bp_src c%0d: got %0d want 1", c, out_src); end
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %b want 1", c, out_valid); end
      n_chk++; if (dut.r_ptr !== 2'd2) begin n_fail++; $display("FAIL bp_ptr c%0d: got %0d want 2", c, dut.r_ptr); end
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
    tick();
    n_chk++; if (out_src !== 2'd2) begin n_fail++; $display("FAIL bp_release_src: got %0d want 2", out_src); end
    n_chk++; if (out_data !== 8'h12) begin n_fail++; $display("FAIL bp_release_data: got %h want 12", out_data); end
    n_chk++; if (dut.r_ptr !== 2'd3) begin n_fail++; $display("FAIL bp_release_ptr: got %0d want 3", dut.r_ptr); end
  endtask

  // Continues from ptr=3 left by the backpressure release grant to requester 2.
  task automatic test_wrap();
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0: got %b want 0001", in_ready); end
    tick();
    n_chk++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL wrap_src0: got %0d want 0", out_src); end
    #1;
    n_chk++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_ready1: got %b want 0010", in_ready); end
    tick();
    n_chk++; if (out_src !== 2'd1) begin n_fail++; $display("FAIL wrap_src1: got %0d want 1", out_src); end
    tick();
    n_chk++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL wrap_src2: got %0d want 0", out_src); end
    n_chk++; if (out_data !== 8'h10) begin n_fail++; $display("FAIL wrap_data2: got %h want 10", out_data); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    in_data   = '0;
    in_data[0 +: WIDTH] = 8'h33;
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    n_chk++; if (out_data !== 8'h33) begin n_fail++; $display("FAIL ar_pre_data: got %h want 33", out_data); end
    n_chk++; if (dut.r_ptr !== 2'd1) begin n_fail++; $display("FAIL ar_pre_ptr: got %0d want 1", dut.r_ptr); end
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL ar_data: got %h want 00", out_data); end
    n_chk++; if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL ar_ptr: got %0d want 0", dut.r_ptr); end
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_data_inc();
    in_valid = 4'b1111;
    tick();
    n_chk++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL ar_next_src: got %0d want 0", out_src); end
    n_chk++; if (out_data !== 8'h10) begin n_fail++; $display("FAIL ar_next_data: got %h want 10", out_data); end
    in_valid = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
